cache_arbiter: RTL and testbench

- Shares one physical-memory / L2 line port between the I-cache miss path and the D-cache miss path of the pipelined rv32i core.
- Sits between the two cache controllers and the memory.
- Grants one line transaction at a time, forwards address, data and handshake, then releases the bus for one cycle.
- Keeps 32-bit per-requester grant counters for performance analysis.

---
 rtl/cache_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates one memory line port between the I-cache and D-cache miss paths.
// Optional macro ARB_ROUND_ROBIN_EN alternates grants when both sides request at once.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [31:0]       i_grant_count,
    output logic [31:0]       d_grant_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] i_count_r;
    logic [31:0] d_count_r;
    logic        i_req_s;
    logic        d_req_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_i_r;
`endif

    assign i_req_s       = i_read;
    assign d_req_s       = d_read | d_write;
    assign i_grant_count = i_count_r;
    assign d_grant_count = d_count_r;

    // Arbitration state, grant counters and last-served side.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            i_count_r <= 32'd0;
            d_count_r <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_i_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (d_req_s && i_req_s) begin
`ifdef ARB_ROUND_ROBIN_EN
                        state_r <= last_i_r ? ST_GRANT_D : ST_GRANT_I;
`else
                        state_r <= ST_GRANT_D;
`endif
                    end else if (d_req_s) begin
                        state_r <= ST_GRANT_D;
                    end else if (i_req_s) begin
                        state_r <= ST_GRANT_I;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT_I: begin
                    if (mem_resp) begin
                        i_count_r <= i_count_r + 32'd1;
                        state_r   <= ST_RELEASE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_i_r  <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_GRANT_I;
                    end
                end
                ST_GRANT_D: begin
                    if (mem_resp) begin
                        d_count_r <= d_count_r + 32'd1;
                        state_r   <= ST_RELEASE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_i_r  <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_GRANT_D;
                    end
                end
                // One dead cycle so memory always sees the strobe drop.
                ST_RELEASE: state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    // Forward the granted side to memory and route the response back.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = {ADDR_W{1'b0}};
        mem_wdata   = {LINE_W{1'b0}};
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        i_rdata     = {LINE_W{1'b0}};
        d_rdata     = {LINE_W{1'b0}};
        case (state_r)
            ST_GRANT_I: begin
                mem_read    = 1'b1;
                mem_address = i_address;
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = mem_rdata;
                end else begin
                    i_resp  = 1'b0;
                end
            end
            ST_GRANT_D: begin
                mem_read    = d_read;
                mem_write   = d_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = mem_rdata;
                end else begin
                    d_resp  = 1'b0;
                end
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
module tb_cache_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam logic [255:0] LINE_I = {32{8'hA5}};
    localparam logic [255:0] LINE_D = {8{32'hC3C3_5A5A}};
    localparam logic [255:0] WDATA  = {8{32'h1234_5678}};

    logic              clk = 1'b0;
    logic              reset;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic [31:0]       i_grant_count;
    logic [31:0]       d_grant_count;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          tb_last_d;
    logic [31:0] exp_i_cnt;
    logic [31:0] exp_d_cnt;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd"},   256'(mem_read),    256'(1'b0));
        check({tag, "_wr"},   256'(mem_write),   256'(1'b0));
        check({tag, "_addr"}, 256'(mem_address), 256'(32'h0));
        check({tag, "_wd"},   mem_wdata,         256'(1'b0));
        check({tag, "_ir"},   256'(i_resp),      256'(1'b0));
        check({tag, "_dr"},   256'(d_resp),      256'(1'b0));
        check({tag, "_ird"},  i_rdata,           256'(1'b0));
        check({tag, "_drd"},  d_rdata,           256'(1'b0));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_icnt"}, 256'(i_grant_count), 256'(exp_i_cnt));
        check({tag, "_dcnt"}, 256'(d_grant_count), 256'(exp_d_cnt));
    endtask

    // Grant choice when both sides request in IDLE.
    function automatic bit pick_both();
`ifdef ARB_ROUND_ROBIN_EN
        return !tb_last_d;
`else
        return 1'b1;
`endif
    endfunction

    // Starts in IDLE; one grant lasting delay+1 cycles, RELEASE, back to IDLE.
    task automatic do_txn(input string tag, input bit exp_d, input int delay,
                          input bit drop_i, input bit rel_req, input logic [255:0] line);
        #1;
        check({tag, "_idle"}, 256'({mem_read, mem_write}), 256'(2'b00));
        step();
        for (int c = 0; c <= delay; c++) begin
            check({tag, "_rd"},   256'(mem_read),  256'(exp_d ? d_read : 1'b1));
            check({tag, "_wr"},   256'(mem_write), 256'(exp_d ? d_write : 1'b0));
            check({tag, "_addr"}, 256'(mem_address), 256'(exp_d ? d_address : i_address));
            check({tag, "_wd"},   mem_wdata, exp_d ? d_wdata : 256'(1'b0));
            if (c < delay) begin
                check({tag, "_wait_resp"}, 256'({i_resp, d_resp}), 256'(2'b00));
                if (drop_i) i_read = 1'b0;
                step();
            end
        end
        mem_rdata = line;
        mem_resp  = 1'b1;
        #1;
        check({tag, "_iresp"}, 256'(i_resp), 256'(!exp_d));
        check({tag, "_dresp"}, 256'(d_resp), 256'(exp_d));
        check({tag, "_irdata"}, i_rdata, exp_d ? 256'(1'b0) : line);
        check({tag, "_drdata"}, d_rdata, exp_d ? line : 256'(1'b0));
        if (exp_d) exp_d_cnt = exp_d_cnt + 32'd1;
        else       exp_i_cnt = exp_i_cnt + 32'd1;
        tb_last_d = exp_d;
        if (rel_req) begin
            if (exp_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read = 1'b0;
            end
        end
        step();
        mem_resp = 1'b0;
        #1;
        check({tag, "_rel_strobe"}, 256'({mem_read, mem_write}), 256'(2'b00));
        check({tag, "_rel_resp"}, 256'({i_resp, d_resp}), 256'(2'b00));
        check({tag, "_rel_ird"}, i_rdata, 256'(1'b0));
        check({tag, "_rel_drd"}, d_rdata, 256'(1'b0));
        check_counts({tag, "_rel"});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        i_read = 1'b0; i_address = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'h0; d_wdata = 256'h0;
        mem_rdata = LINE_I; mem_resp = 1'b0;
        exp_i_cnt = 32'd0; exp_d_cnt = 32'd0; tb_last_d = 1'b1;
        #1;
        check_quiet("reset");
        check_counts("reset");
        i_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0ABC;
        step();
        check_quiet("reset_req");
        i_read = 1'b0; d_write = 1'b0; d_address = 32'h0;
        reset = 1'b0;
        step();

        // Stray memory response with nobody granted.
        mem_resp = 1'b1; mem_rdata = LINE_D;
        #1;
        check_quiet("stray");
        step();
        mem_resp = 1'b0;
        #1;
        check_quiet("stray_after");
        check_counts("stray");

        i_address = 32'h0000_0060; i_read = 1'b1;
        do_txn("imiss", 1'b0, 3, 1'b1, 1'b1, LINE_I);

        d_address = 32'h0000_1000; d_wdata = WDATA; d_write = 1'b1;
        do_txn("dwb", 1'b1, 1, 1'b0, 1'b1, 256'h0);

        begin
            bit first;
            i_address = 32'h0000_2000; d_address = 32'h0000_3000;
            i_read = 1'b1; d_read = 1'b1;
            first = pick_both();
            do_txn("sim1", first, 0, 1'b0, 1'b1, first ? LINE_D : LINE_I);
            do_txn("sim2", !first, 0, 1'b0, 1'b1, first ? LINE_I : LINE_D);
        end

        i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit e;
            e = pick_both();
            do_txn($sformatf("cont%0d", k), e, 0, 1'b0, 1'b0, e ? LINE_D : LINE_I);
        end
        i_read = 1'b0; d_read = 1'b0;

        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_4000;
        do_txn("illegal", 1'b1, 0, 1'b0, 1'b1, LINE_D);

        // Reset one cycle into an I grant.
        i_address = 32'h0000_0060; i_read = 1'b1;
        step();
        check("mid_grant_rd", 256'(mem_read), 256'(1'b1));
        step();
        reset = 1'b1;
        exp_i_cnt = 32'd0; exp_d_cnt = 32'd0; tb_last_d = 1'b1;
        #1;
        check_quiet("mid_reset");
        check_counts("mid_reset");
        i_read = 1'b0; mem_resp = 1'b1; mem_rdata = LINE_I;
        #1;
        check_quiet("mid_reset_resp");
        step();
        reset = 1'b0;
        #1;
        check_quiet("post_reset_resp");
        step();
        mem_resp = 1'b0;
        #1;
        check_quiet("post_reset_idle");
        check_counts("post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
